// File: rtl/sr_pkg.sv
// Shared types and helpers for the sr_universal shift register.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SHL  = 2'd1,
    SR_SHR  = 2'd2,
    SR_LOAD = 2'd3
  } sr_mode_e;

  // Count must hold 0..WIDTH-1, sized like the rest of the family at WIDTH+1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sr_word_counter.sv
// Word-boundary counter: counts shifts and pulses word_valid_o when a full word is in.
module sr_word_counter
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      shift_i,
  input  logic                      load_i,
  output logic [cnt_w(WIDTH)-1:0]   count_o,
  output logic                      word_valid_o
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] count_q, count_d;
  logic          wv_q, wv_d;

  always_comb begin
    count_d = count_q;
    wv_d    = 1'b0;
    // A load restarts the word even if a shift would have completed it.
    if (load_i) begin
      count_d = '0;
    end else if (shift_i) begin
      if (count_q == CW'(WIDTH - 1)) begin
        count_d = '0;
        wv_d    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wv_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wv_q    <= wv_d;
    end
  end

  assign count_o      = count_q;
  assign word_valid_o = wv_q;

endmodule

// File: rtl/sr_universal.sv
// Universal shift register: hold / shift-left / shift-right / parallel load with word tracking.
// Optional rotate input enabled by defining SR_ROTATE_EN.
module sr_universal
  import sr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  sr_mode_e                mode,
  input  logic                    data_in,
`ifdef SR_ROTATE_EN
  input  logic                    rotate,
`endif
  input  logic [WIDTH-1:0]        par_in,
  output logic                    data_out,
  output logic [WIDTH-1:0]        par_out,
  output logic [cnt_w(WIDTH)-1:0] count,
  output logic                    word_valid
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             dout_q, dout_d;
  logic             ins_l, ins_r;
  logic             shift, load;

  assign shift = enable && ((mode == SR_SHL) || (mode == SR_SHR));
  assign load  = enable && (mode == SR_LOAD);

  always_comb begin
    ins_l = data_in;
    ins_r = data_in;
`ifdef SR_ROTATE_EN
    if (rotate) begin
      ins_l = reg_q[WIDTH-1];
      ins_r = reg_q[0];
    end
`endif
  end

  always_comb begin
    reg_d  = reg_q;
    dout_d = dout_q;
    if (enable) begin
      case (mode)
        SR_SHL: begin
          reg_d  = {reg_q[WIDTH-2:0], ins_l};
          dout_d = reg_q[WIDTH-1];
        end
        SR_SHR: begin
          reg_d  = {ins_r, reg_q[WIDTH-1:1]};
          dout_d = reg_q[0];
        end
        SR_LOAD: reg_d = par_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q  <= RESET_VAL;
      dout_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      dout_q <= dout_d;
    end
  end

  sr_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .shift_i      (shift),
    .load_i       (load),
    .count_o      (count),
    .word_valid_o (word_valid)
  );

  assign par_out  = reg_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_sr_universal.sv
// Directed-vector bench for sr_universal at WIDTH=8, RESET_VAL=0.
module tb_sr_universal;
  import sr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  sr_mode_e   mode;
  logic       data_in;
  logic       rotate;
  logic [7:0] par_in;
  logic       data_out;
  logic [7:0] par_out;
  logic [3:0] count;
  logic       word_valid;

  int n_tests = 0;
  int n_fail  = 0;

  sr_universal #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .data_in    (data_in),
`ifdef SR_ROTATE_EN
    .rotate     (rotate),
`endif
    .par_in     (par_in),
    .data_out   (data_out),
    .par_out    (par_out),
    .count      (count),
    .word_valid (word_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input sr_mode_e m, input logic din, input logic en, input logic [7:0] p);
    mode    = m;
    data_in = din;
    enable  = en;
    par_in  = p;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ser_exp;
  logic [7:0] des_bits;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    mode    = SR_HOLD;
    data_in = 1'b0;
    rotate  = 1'b0;
    par_in  = 8'h00;
    #12;
    chk("rst_par",  par_out,    8'h00);
    chk("rst_dout", data_out,   1'b0);
    chk("rst_cnt",  count,      4'd0);
    chk("rst_wv",   word_valid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Serialise A5 MSB-first
    step(SR_LOAD, 1'b0, 1'b1, 8'hA5);
    chk("ser_load", par_out, 8'hA5);
    chk("ser_load_cnt", count, 4'd0);
    ser_exp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(SR_SHL, 1'b0, 1'b1, 8'h00);
      chk($sformatf("ser_dout%0d", i), data_out, ser_exp[7-i]);
      chk($sformatf("ser_wv%0d", i), word_valid, (i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("ser_cnt%0d", i), count, (i == 7) ? 4'd0 : 4'(i + 1));
    end
    chk("ser_par_end", par_out, 8'h00);
    step(SR_HOLD, 1'b0, 1'b1, 8'h00);
    chk("ser_wv_drop", word_valid, 1'b0);

    // Deserialise 1,1,0,0,1,0,1,0 from reset
    reset = 1'b1;
    #1 reset = 1'b0;
    des_bits = 8'hCA;
    for (int i = 0; i < 8; i++) begin
      step(SR_SHL, des_bits[7-i], 1'b1, 8'h00);
      chk($sformatf("des_wv%0d", i), word_valid, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("des_par", par_out, 8'hCA);
    chk("des_cnt", count, 4'd0);
    step(SR_HOLD, 1'b0, 1'b1, 8'h00);
    chk("des_wv_once", word_valid, 1'b0);
    chk("des_hold_par", par_out, 8'hCA);

    // Enable gating
    step(SR_LOAD, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step(SR_SHR, 1'b1, 1'b0, 8'hFF);
      chk($sformatf("gate_par%0d", i), par_out, 8'h3C);
      chk($sformatf("gate_cnt%0d", i), count, 4'd0);
      chk($sformatf("gate_wv%0d", i), word_valid, 1'b0);
    end

    // LOAD mid-word clears count, data_out holds
    step(SR_SHL, 1'b0, 1'b1, 8'h00);  // 3C<<1 = 78, dout=0
    step(SR_SHL, 1'b0, 1'b1, 8'h00);  // F0, dout=0
    step(SR_SHL, 1'b0, 1'b1, 8'h00);  // E0, dout=1
    chk("mid_cnt", count, 4'd3);
    chk("mid_dout", data_out, 1'b1);
    step(SR_LOAD, 1'b0, 1'b1, 8'h5A);
    chk("ld_par", par_out, 8'h5A);
    chk("ld_cnt", count, 4'd0);
    chk("ld_dout_hold", data_out, 1'b1);

    // Async reset mid-word
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) step(SR_SHR, 1'b1, 1'b1, 8'h00);
    chk("ar_pre_par", par_out, 8'hE0);
    chk("ar_pre_cnt", count, 4'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_par",  par_out,  8'h00);
    chk("ar_cnt",  count,    4'd0);
    chk("ar_dout", data_out, 1'b0);
    #1 reset = 1'b0;
    step(SR_SHL, 1'b1, 1'b1, 8'h00);
    chk("ar_post_par", par_out, 8'h01);
    chk("ar_post_cnt", count, 4'd1);

    // Direction change keeps counting
    step(SR_LOAD, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step((i < 4) ? SR_SHL : SR_SHR, 1'b1, 1'b1, 8'h00);
      chk($sformatf("dir_cnt%0d", i), count, (i == 7) ? 4'd0 : 4'(i + 1));
      chk($sformatf("dir_wv%0d", i), word_valid, (i == 7) ? 1'b1 : 1'b0);
    end

`ifdef SR_ROTATE_EN
    step(SR_LOAD, 1'b0, 1'b1, 8'h81);
    rotate = 1'b1;
    step(SR_SHR, 1'b0, 1'b1, 8'h00);
    chk("rot_shr_par",  par_out,  8'hC0);
    chk("rot_shr_dout", data_out, 1'b1);
    step(SR_SHL, 1'b0, 1'b1, 8'h00);
    chk("rot_shl_par",  par_out,  8'h81);
    rotate = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sr_universal.md
Name: sr_universal

Overview:
- Parametrised universal shift register, successor to the single-bit serial shift register.
- Supports hold, shift-left, shift-right and parallel load, with serial and parallel in/out.
- Tracks a word-boundary count and pulses when a full word has been shifted in.
- Used as both serialiser and deserialiser in the shift-register datapath; driven and monitored through the existing clocking-block interface style.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RESET_VAL, '0 (WIDTH bits), value loaded into the register on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  clock-enable; when low, all state holds.
- mode  in  2  operation select (sr_mode_e): HOLD=0, SHL=1, SHR=2, LOAD=3.
- data_in  in  1  serial input bit.
- par_in  in  WIDTH  parallel load value.
- data_out  out  1  registered serial output (the bit shifted out).
- par_out  out  WIDTH  current register contents.
- count  out  $clog2(WIDTH+1)  bits shifted since the last word boundary or load.
- word_valid  out  1  one-cycle pulse marking a word boundary.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset (immediate, independent of clk):
  - par_out=RESET_VAL, data_out=0, count=0, word_valid=0.
  - Asserting reset mid-word discards partial state; the first edge after deassertion behaves as a normal cycle.
- enable=0: register, data_out and count hold; word_valid=0. mode is ignored.
- enable=1, HOLD: register, data_out and count hold; word_valid=0.
- enable=1, SHL:
  - reg <= {reg[WIDTH-2:0], data_in}.
  - data_out <= reg[WIDTH-1].
- enable=1, SHR:
  - reg <= {data_in, reg[WIDTH-1:1]}.
  - data_out <= reg[0].
- enable=1, LOAD:
  - reg <= par_in; count <= 0; word_valid <= 0.
  - data_out holds.
- Count, on any SHL/SHR cycle:
  - if count==WIDTH-1: count <= 0, word_valid <= 1.
  - else: count <= count+1, word_valid <= 0.
  - Count never reaches WIDTH.
  - Direction change mid-word does not clear count.
- Latency:
  - par_out reflects the shift one cycle after the enabled edge.
  - A serial bit entering at data_in appears on data_out after WIDTH+1 enabled shifts in the same direction.
- Simultaneous events: reset dominates everything. LOAD dominates the count update. There are no other concurrent sources.
- mode is sampled only when enable=1.

Optional Feature:
- Macro: SR_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit).
  - When rotate=1 during SHL, the inserted bit is reg[WIDTH-1]; during SHR, it is reg[0]. data_in is ignored.
  - data_out and count behave exactly as in a normal shift.
  - rotate has no effect in HOLD/LOAD.
- Undefined: the rotate port is absent and shifts always insert data_in.

Decomposition:
- Package sr_pkg holds:
  - typedef enum logic [1:0] sr_mode_e {SR_HOLD, SR_SHL, SR_SHR, SR_LOAD}.
  - localparam function for the count width.
- One natural sub-module, sr_word_counter:
  - Inputs: shift strobe, load/clear.
  - Outputs: count and word_valid.
  - Parametrised by WIDTH.
- Register and mux logic stay in the top level.
- Bench interface extends the existing style: driver, write-monitor and read-monitor clocking blocks/modports, with par_in/mode added on the drive side and par_out/count/word_valid added on the read side.

Test Plan (WIDTH=8, RESET_VAL=0):
- Serialise: LOAD par_in=8'hA5, then 8×SHL with data_in=0 -> data_out sequence 1,0,1,0,0,1,0,1; par_out=8'h00 at the end; word_valid pulses once, after the 8th shift.
- Deserialise: from reset, 8×SHL feeding 1,1,0,0,1,0,1,0 -> par_out=8'hCA; count returns to 0; word_valid=1 for exactly one cycle.
- Enable gating: LOAD 8'h3C, then enable=0 with mode=SHR for 5 cycles -> par_out stays 8'h3C, count stays 0, word_valid stays 0.
- Async reset mid-word: 3×SHR with data_in=1, then pulse reset between edges -> par_out=8'h00, count=0, data_out=0 before the next edge.
- Direction change: 4×SHL, then 4×SHR -> count 1..7, then 0 with a word_valid pulse on the 8th shift.
- Rotate (SR_ROTATE_EN defined): LOAD 8'h81, SHR with rotate=1 -> par_out=8'hC0, data_out=1; then SHL with rotate=1 -> par_out=8'h81.
